alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter and sequencer for one shared 20-bit ALU.
// A request is accepted in IDLE, the ALU runs for one EXEC cycle on the
// registered operands, and the result is held in RESP until rsp_ready.

// Shared ALU: add, sub, and, or, xor; ops 101-111 give s=0.
// Equality output: be_select=1 -> e = (i0 == i1), be_select=0 -> e = (i0 != i1).
module ALU (
   input  logic [2:0]  op_select,
   input  logic        be_select,
   input  logic [19:0] i0,
   input  logic [19:0] i1,
   output logic [19:0] s,
   output logic        cout,
   output logic        e
);
   logic [20:0] wide;

   // result mux; carry/borrow is bit 20 of the 21-bit add/sub
   always_comb begin
      wide = 21'd0;
      s    = 20'd0;
      cout = 1'b0;
      case (op_select)
         3'b000: begin
            wide = {1'b0, i0} + {1'b0, i1};
            s    = wide[19:0];
            cout = wide[20];
         end
         3'b001: begin
            wide = {1'b0, i0} - {1'b0, i1};
            s    = wide[19:0];
            cout = wide[20];
         end
         3'b010:  s = i0 & i1;
         3'b011:  s = i0 | i1;
         3'b100:  s = i0 ^ i1;
         default: s = 20'd0;
      endcase
      e = be_select ? (i0 == i1) : (i0 != i1);
   end
endmodule

module alu_arbiter #(
   parameter int FAIR = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid0,
   input  logic        req_valid1,
   output logic        req_ready0,
   output logic        req_ready1,
   input  logic [2:0]  req_op0,
   input  logic [2:0]  req_op1,
   input  logic        req_be0,
   input  logic        req_be1,
   input  logic [19:0] req_a0,
   input  logic [19:0] req_b0,
   input  logic [19:0] req_a1,
   input  logic [19:0] req_b1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [19:0] rsp_s,
   output logic        rsp_cout,
   output logic        rsp_e,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_next;
   logic        grant;
   logic        any_valid;
   logic        last_grant;
   logic        id_r;
   logic [2:0]  op_r;
   logic        be_r;
   logic [19:0] a_r, b_r;
   logic [19:0] alu_s;
   logic        alu_cout, alu_e;

   ALU u_alu (
      .op_select (op_r),
      .be_select (be_r),
      .i0        (a_r),
      .i1        (b_r),
      .s         (alu_s),
      .cout      (alu_cout),
      .e         (alu_e)
   );

   // grant selection: single requester wins outright, ties by FAIR mode
   always_comb begin
      any_valid = req_valid0 | req_valid1;
      if (req_valid0 && req_valid1)
         grant = (FAIR != 0) ? ~last_grant : 1'b0;
      else
         grant = req_valid1;
   end

   // state register; rsp_valid and busy are registered copies of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         rsp_valid <= (state_next == RESP);
         busy      <= (state_next != IDLE);
      end
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_valid) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // request-side ready: only the granted, valid requester in IDLE
   always_comb begin
      req_ready0 = (state == IDLE) && req_valid0 && (grant == 1'b0);
      req_ready1 = (state == IDLE) && req_valid1 && (grant == 1'b1);
   end

   // operand capture on accept, result capture at the end of EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r       <= 3'd0;
         be_r       <= 1'b0;
         a_r        <= 20'd0;
         b_r        <= 20'd0;
         id_r       <= 1'b0;
         last_grant <= 1'b1;
         rsp_id     <= 1'b0;
         rsp_s      <= 20'd0;
         rsp_cout   <= 1'b0;
         rsp_e      <= 1'b0;
      end else begin
         if (state == IDLE && any_valid) begin
            op_r       <= grant ? req_op1 : req_op0;
            be_r       <= grant ? req_be1 : req_be0;
            a_r        <= grant ? req_a1  : req_a0;
            b_r        <= grant ? req_b1  : req_b0;
            id_r       <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_s    <= alu_s;
            rsp_cout <= alu_cout;
            rsp_e    <= alu_e;
            rsp_id   <= id_r;
         end
      end
   end
endmodule
